// File: rtl/sample_circuit_bist_ctrl_if.sv
// sample_circuit_bist_ctrl_if: control, status and DUT-stimulus bundle of the BIST sequencer
interface sample_circuit_bist_ctrl_if #(
    parameter int WIDTH     = 3,
    parameter int ERR_CNT_W = 8
);
    logic                   start;
    logic                   abort;
    logic                   busy;
    logic                   done;
    logic                   pass;
    logic [WIDTH-1:0]       a_o;
    logic [WIDTH-1:0]       b_o;
    logic [WIDTH-1:0]       c_o;
    logic [WIDTH-1:0]       y_i;
    logic [ERR_CNT_W-1:0]   err_count;
    logic                   first_fail_valid;
    logic [3*WIDTH-1:0]     first_fail_pat;
    modport master (
        output start, abort, y_i,
        input  busy, done, pass, a_o, b_o, c_o, err_count, first_fail_valid, first_fail_pat
    );
    modport slave (
        input  start, abort, y_i,
        output busy, done, pass, a_o, b_o, c_o, err_count, first_fail_valid, first_fail_pat
    );
endinterface

// File: rtl/sample_circuit_bist_ctrl.sv
// sample_circuit_bist_ctrl: exhaustive BIST sweep of y = (c | (a & b)) & ~a with error count and first-fail capture.
// Define SAMPLE_BIST_STOP_ON_FAIL_EN to end the run at the first mismatch, leaving the failing pattern on a_o/b_o/c_o.
module sample_circuit_bist_ctrl #(
    parameter int WIDTH         = 3,
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_CNT_W     = 8
) (
    input logic clk,
    input logic rst,
    sample_circuit_bist_ctrl_if.slave bus
);
    localparam int PW = 3 * WIDTH;
    localparam int CW = $clog2(SETTLE_CYCLES + 2);
    typedef enum logic [2:0] {IDLE, APPLY, SETTLE, CHECK, DONE} state_t;
    state_t               state_q, state_d;
    logic [PW-1:0]        pat_q, pat_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [ERR_CNT_W-1:0] err_q, err_d;
    logic                 ffv_q, ffv_d;
    logic [PW-1:0]        ffp_q, ffp_d;
    logic                 pass_q, pass_d;
    logic [WIDTH-1:0]     a, b, c, expv;
    logic                 mis, run;
    assign {c, b, a} = pat_q;
    assign expv      = (c | (a & b)) & ~a;
    assign mis       = bus.y_i != expv;
    assign run       = state_q inside {APPLY, SETTLE, CHECK};
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        ffv_d   = ffv_q;
        ffp_d   = ffp_q;
        pass_d  = pass_q;
        case (state_q)
            IDLE: if (bus.start) begin
                state_d = APPLY;
                pat_d   = '0;
                err_d   = '0;
                ffv_d   = 1'b0;
                ffp_d   = '0;
                pass_d  = 1'b0;
            end
            APPLY: begin
                state_d = SETTLE_CYCLES > 0 ? SETTLE : CHECK;
                cnt_d   = '0;
            end
            SETTLE: begin
                cnt_d   = cnt_q + 1'b1;
                state_d = int'(cnt_q) + 1 >= SETTLE_CYCLES ? CHECK : SETTLE;
            end
            CHECK: begin
                if (mis) begin
                    err_d = &err_q ? err_q : err_q + 1'b1;
                    if (!ffv_q) begin
                        ffv_d = 1'b1;
                        ffp_d = pat_q;
                    end
                end
`ifdef SAMPLE_BIST_STOP_ON_FAIL_EN
                if (&pat_q || mis) begin
`else
                if (&pat_q) begin
`endif
                    state_d = DONE;
                    pass_d  = !ffv_d;
                end else begin
                    state_d = APPLY;
                    pat_d   = pat_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // abort outranks everything in a run, including a final or failing CHECK
        if (bus.abort && run) begin
            state_d = IDLE;
            pat_d   = pat_q;
            err_d   = err_q;
            ffv_d   = ffv_q;
            ffp_d   = ffp_q;
            pass_d  = 1'b0;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pat_q   <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            ffv_q   <= 1'b0;
            ffp_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            ffv_q   <= ffv_d;
            ffp_q   <= ffp_d;
            pass_q  <= pass_d;
        end
    end
    assign bus.busy             = run;
    assign bus.done             = state_q == DONE;
    assign bus.pass             = pass_q;
    assign bus.a_o              = a;
    assign bus.b_o              = b;
    assign bus.c_o              = c;
    assign bus.err_count        = err_q;
    assign bus.first_fail_valid = ffv_q;
    assign bus.first_fail_pat   = ffp_q;
endmodule

// File: tb/tb_sample_circuit_bist_ctrl.sv
// tb_sample_circuit_bist_ctrl: drives the sequencer against a stuck-at-masked sample_circuit model and
// checks results against an exhaustive-sweep reference computed per run.
module tb_sample_circuit_bist_ctrl;
    logic clk = 1'b0;
    logic rst;
    logic [2:0] am = 3'b111;
    logic [2:0] om = 3'b000;
    int total = 0;
    int bad   = 0;
    always #5 clk = ~clk;

    sample_circuit_bist_ctrl_if #(.WIDTH(3), .ERR_CNT_W(8)) m ();
    sample_circuit_bist_ctrl_if #(.WIDTH(3), .ERR_CNT_W(8)) z ();

    function automatic logic [2:0] faulty(input logic [2:0] a, b, c, input logic [2:0] andm, orm);
        return (((c | (a & b)) & ~a) & andm) | orm;
    endfunction

    assign m.y_i = faulty(m.a_o, m.b_o, m.c_o, am, om);
    assign z.y_i = faulty(z.a_o, z.b_o, z.c_o, am, om);

    sample_circuit_bist_ctrl #(.WIDTH(3), .SETTLE_CYCLES(2), .ERR_CNT_W(8)) u_dut (.clk(clk), .rst(rst), .bus(m));
    sample_circuit_bist_ctrl #(.WIDTH(3), .SETTLE_CYCLES(0), .ERR_CNT_W(8)) u_dz  (.clk(clk), .rst(rst), .bus(z));

    typedef struct {
        logic [2:0] andm;
        logic [2:0] orm;
        int         err;
        int         ffp;
        bit         ffv;
        bit         pass;
    } vec_t;
    vec_t tbl[3];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, wanted %0d", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Sweep every pattern with plain arithmetic to get the run outcome.
    task automatic model(input logic [2:0] andm, orm, input int s, output int err, output int ffp,
                         output bit ffv, output bit pass, output int cyc, output int last);
        logic [2:0] a, b, c, g;
        err = 0; ffp = 0; ffv = 0;
        for (int p = 0; p < 512; p++) begin
            a = p[2:0]; b = p[5:3]; c = p[8:6];
            g = (c | (a & b)) & ~a;
            if (((g & andm) | orm) != g) begin
                if (!ffv) ffp = p;
                ffv = 1;
                err++;
            end
        end
        pass = !ffv;
`ifdef SAMPLE_BIST_STOP_ON_FAIL_EN
        if (ffv) begin
            err  = 1;
            cyc  = 1 + (ffp + 1) * (s + 2);
            last = ffp;
        end else begin
            cyc  = 1 + 512 * (s + 2);
            last = 511;
        end
`else
        err  = err > 255 ? 255 : err;
        cyc  = 1 + 512 * (s + 2);
        last = 511;
`endif
    endtask

    task automatic run_main(input string tag, input bit stray, input int ecyc, input int eerr,
                            input int effp, input bit effv, input bit epass, input int elast);
        int cyc;
        m.start = 1'b1;
        tick;
        m.start = 1'b0;
        cyc = 1;
        chk({tag, "_busy_at_apply"}, m.busy, 1);
        while (!m.done && cyc < 6000) begin
            m.start = stray && ($urandom_range(0, 39) == 0);
            tick;
            cyc++;
        end
        m.start = 1'b0;
        chk({tag, "_done_cycle"}, cyc, ecyc);
        chk({tag, "_pass"}, m.pass, epass);
        chk({tag, "_err_count"}, m.err_count, eerr);
        chk({tag, "_ffv"}, m.first_fail_valid, effv);
        chk({tag, "_ffp"}, m.first_fail_pat, effp);
        chk({tag, "_last_pat"}, {m.c_o, m.b_o, m.a_o}, elast);
        tick;
        chk({tag, "_done_1cyc"}, m.done, 0);
        chk({tag, "_idle"}, m.busy, 0);
        repeat (3) tick;
        chk({tag, "_pass_hold"}, m.pass, epass);
        chk({tag, "_err_hold"}, m.err_count, eerr);
        chk({tag, "_ffp_hold"}, m.first_fail_pat, effp);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_busy"}, m.busy, 0);
        chk({tag, "_done"}, m.done, 0);
        chk({tag, "_pass"}, m.pass, 0);
        chk({tag, "_abc"}, {m.c_o, m.b_o, m.a_o}, 0);
        chk({tag, "_err"}, m.err_count, 0);
        chk({tag, "_ffv"}, m.first_fail_valid, 0);
        chk({tag, "_ffp"}, m.first_fail_pat, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int err, ffp, cyc, last;
        bit ffv, pass;
        bit seen;
`ifdef SAMPLE_BIST_STOP_ON_FAIL_EN
        tbl[0] = '{3'b111, 3'b000, 0,   0,      0, 1};
        tbl[1] = '{3'b011, 3'b000, 1,   'h100,  1, 0};
        tbl[2] = '{3'b111, 3'b001, 1,   0,      1, 0};
`else
        tbl[0] = '{3'b111, 3'b000, 0,   0,      0, 1};
        tbl[1] = '{3'b011, 3'b000, 128, 'h100,  1, 0};
        tbl[2] = '{3'b111, 3'b001, 255, 0,      1, 0};
`endif
        rst = 1'b1;
        m.start = 1'b0; m.abort = 1'b0;
        z.start = 1'b0; z.abort = 1'b0;
        tick; tick;
        rst = 1'b0;
        chk_reset("reset");
        chk("reset_z_busy", z.busy, 0);

        for (int i = 0; i < 3; i++) begin
            am = tbl[i].andm; om = tbl[i].orm;
            model(am, om, 2, err, ffp, ffv, pass, cyc, last);
            chk($sformatf("vec%0d_model_err", i), err, tbl[i].err);
            run_main($sformatf("vec%0d", i), i == 0, cyc, tbl[i].err, tbl[i].ffp, tbl[i].ffv, tbl[i].pass, last);
        end

        for (int r = 0; r < 3; r++) begin
            am = 3'($urandom_range(0, 7));
            om = 3'($urandom_range(0, 7) & $urandom_range(0, 7));
            model(am, om, 2, err, ffp, ffv, pass, cyc, last);
            run_main($sformatf("rnd%0d", r), 1, cyc, err, ffp, ffv, pass, last);
        end

        am = 3'b111; om = 3'b000;
        z.start = 1'b1;
        tick;
        z.start = 1'b0;
        cyc = 1;
        while (!z.done && cyc < 3000) begin
            tick;
            cyc++;
        end
        chk("settle0_done_cycle", cyc, 1025);
        chk("settle0_pass", z.pass, 1);
        chk("settle0_err", z.err_count, 0);

        m.start = 1'b1;
        tick;
        m.start = 1'b0;
        repeat (9) tick;
        m.abort = 1'b1;
        tick;
        m.abort = 1'b0;
        chk("abort_busy", m.busy, 0);
        chk("abort_pass", m.pass, 0);
        chk("abort_err_hold", m.err_count, 0);
        seen = 0;
        for (int i = 0; i < 2200; i++) begin
            if (m.done || m.busy) seen = 1;
            tick;
        end
        chk("abort_no_done", seen, 0);
        run_main("after_abort", 0, 2049, 0, 0, 0, 1, 511);

        m.start = 1'b1;
        tick;
        m.start = 1'b0;
        repeat (9) tick;
        chk("mid_settle_busy", m.busy, 1);
        chk("mid_settle_pat", {m.c_o, m.b_o, m.a_o}, 2);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk_reset("rst_mid");
        repeat (2050) tick;
        chk("rst_mid_no_run", m.busy | m.done, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
